// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd
// MM:SS stopwatch with four BCD digit counters and an IDLE/RUN/PAUSE control FSM.
// The count advances once per tick_1s strobe while running; wrap pulses for one
// cycle when the count rolls over from (MAX_MIN-1):59 to 00:00.
// Optional feature macro: STOPWATCH_LAP_EN adds the lap port and a lap-hold
// register that freezes the displayed digits while counting continues.
module stopwatch_bcd #(
    parameter int MAX_MIN = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       start_stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       wrap
);

    // FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // BCD digits of the last legal minute value (MAX_MIN-1)
    localparam logic [3:0] MAX_MIN_HI = 4'((MAX_MIN - 1) / 10);
    localparam logic [3:0] MAX_MIN_LO = 4'((MAX_MIN - 1) % 10);

    // Increment one BCD digit that rolls over after 'top'; returns {carry, next}.
    // Any out-of-range value is pulled back to zero so a digit cannot stay
    // outside its legal range.
    function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic [3:0] top);
        logic [4:0] result;
        if (digit >= top) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

    logic [1:0] state_r;
    logic [1:0] state_n_s;
    logic [3:0] sec_lo_r;
    logic [3:0] sec_hi_r;
    logic [3:0] min_lo_r;
    logic [3:0] min_hi_r;
    logic [3:0] sec_lo_n_s;
    logic [3:0] sec_hi_n_s;
    logic [3:0] min_lo_n_s;
    logic [3:0] min_hi_n_s;
    logic       wrap_r;
    logic       inc_s;
    logic       at_max_s;
    logic [4:0] sec_lo_inc_s;
    logic [4:0] sec_hi_inc_s;
    logic [4:0] min_lo_inc_s;
    logic [4:0] min_hi_inc_s;

    // Counting decisions use the current state; clear suppresses any increment
    assign inc_s    = (state_r == ST_RUN) && tick_1s && !clear;
    assign at_max_s = (sec_lo_r == 4'd9) && (sec_hi_r == 4'd5) &&
                      (min_lo_r == MAX_MIN_LO) && (min_hi_r == MAX_MIN_HI);

    assign sec_lo_inc_s = bcd_inc(sec_lo_r, 4'd9);
    assign sec_hi_inc_s = bcd_inc(sec_hi_r, 4'd5);
    assign min_lo_inc_s = bcd_inc(min_lo_r, 4'd9);
    assign min_hi_inc_s = bcd_inc(min_hi_r, 4'd9);

    // Next-state logic: clear has priority, start_stop toggles run/pause
    always_comb begin
        state_n_s = state_r;
        if (clear) begin
            state_n_s = ST_IDLE;
        end else if (start_stop) begin
            case (state_r)
                ST_IDLE:  state_n_s = ST_RUN;
                ST_RUN:   state_n_s = ST_PAUSE;
                ST_PAUSE: state_n_s = ST_RUN;
                default:  state_n_s = ST_IDLE;
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next digit values: clear, terminal-count reload, or rippled BCD carry
    always_comb begin
        sec_lo_n_s = sec_lo_r;
        sec_hi_n_s = sec_hi_r;
        min_lo_n_s = min_lo_r;
        min_hi_n_s = min_hi_r;
        if (clear) begin
            sec_lo_n_s = 4'd0;
            sec_hi_n_s = 4'd0;
            min_lo_n_s = 4'd0;
            min_hi_n_s = 4'd0;
        end else if (inc_s) begin
            if (at_max_s) begin
                sec_lo_n_s = 4'd0;
                sec_hi_n_s = 4'd0;
                min_lo_n_s = 4'd0;
                min_hi_n_s = 4'd0;
            end else begin
                sec_lo_n_s = sec_lo_inc_s[3:0];
                if (sec_lo_inc_s[4]) begin
                    sec_hi_n_s = sec_hi_inc_s[3:0];
                    if (sec_hi_inc_s[4]) begin
                        min_lo_n_s = min_lo_inc_s[3:0];
                        if (min_lo_inc_s[4]) begin
                            min_hi_n_s = min_hi_inc_s[3:0];
                        end else begin
                            min_hi_n_s = min_hi_r;
                        end
                    end else begin
                        min_lo_n_s = min_lo_r;
                    end
                end else begin
                    sec_hi_n_s = sec_hi_r;
                end
            end
        end else begin
            sec_lo_n_s = sec_lo_r;
        end
    end

    // Live count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_lo_r <= 4'd0;
            sec_hi_r <= 4'd0;
            min_lo_r <= 4'd0;
            min_hi_r <= 4'd0;
        end else begin
            sec_lo_r <= sec_lo_n_s;
            sec_hi_r <= sec_hi_n_s;
            min_lo_r <= min_lo_n_s;
            min_hi_r <= min_hi_n_s;
        end
    end

    // Rollover pulse: high for exactly the cycle after the terminal increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= inc_s && at_max_s;
        end
    end

    assign running = (state_r == ST_RUN);
    assign wrap    = wrap_r;

`ifdef STOPWATCH_LAP_EN
    logic       frozen_r;
    logic [3:0] hold_sec_lo_r;
    logic [3:0] hold_sec_hi_r;
    logic [3:0] hold_min_lo_r;
    logic [3:0] hold_min_hi_r;

    // Lap hold: capture on lap in RUN, release on the next lap or any command;
    // start_stop releases even when it coincides with lap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frozen_r      <= 1'b0;
            hold_sec_lo_r <= 4'd0;
            hold_sec_hi_r <= 4'd0;
            hold_min_lo_r <= 4'd0;
            hold_min_hi_r <= 4'd0;
        end else if (clear) begin
            frozen_r      <= 1'b0;
            hold_sec_lo_r <= 4'd0;
            hold_sec_hi_r <= 4'd0;
            hold_min_lo_r <= 4'd0;
            hold_min_hi_r <= 4'd0;
        end else if (start_stop) begin
            frozen_r <= 1'b0;
        end else if (lap && (state_r == ST_RUN)) begin
            if (frozen_r) begin
                frozen_r <= 1'b0;
            end else begin
                frozen_r      <= 1'b1;
                hold_sec_lo_r <= sec_lo_r;
                hold_sec_hi_r <= sec_hi_r;
                hold_min_lo_r <= min_lo_r;
                hold_min_hi_r <= min_hi_r;
            end
        end else begin
            frozen_r <= frozen_r;
        end
    end

    assign sec_lo = frozen_r ? hold_sec_lo_r : sec_lo_r;
    assign sec_hi = frozen_r ? hold_sec_hi_r : sec_hi_r;
    assign min_lo = frozen_r ? hold_min_lo_r : min_lo_r;
    assign min_hi = frozen_r ? hold_min_hi_r : min_hi_r;
`else
    assign sec_lo = sec_lo_r;
    assign sec_hi = sec_hi_r;
    assign min_lo = min_lo_r;
    assign min_hi = min_hi_r;
`endif

endmodule
